contact_resolve_scheduler: RTL and testbench
============================================

CONTACT_RESOLVE_SCHEDULER -- requirements
Module: contact_resolve_scheduler

Interface
REQ-001 Parameter N_BODIES, default 16: number of bodies in body-state memory; ID_W = clog2(N_BODIES).
REQ-002 Parameter FIFO_DEPTH, default 8: contact queue entries, power of two.
REQ-003 Parameter CONTACT_W, default 96: packed contact record width (location, normal, penetration).
REQ-004 Parameter BODY_W, default 256: packed body record width; fields pos_x, pos_y, vel_x, vel_y and omega are 32-bit two's-complement; the remaining fields are constants.
REQ-005 Clk  in  1  sole clock; all logic is rising-edge.
REQ-006 Reset  in  1  asynchronous, active-high.
REQ-007 contact_valid / contact_ready  in / out  1 / 1  contact push handshake.
REQ-008 contact_id_a, contact_id_b  in  ID_W each  body indices of the contact.
REQ-009 contact_data  in  CONTACT_W  contact record.
REQ-010 mem_req / mem_gnt  out / in  1 / 1  shared body-memory port request and grant.
REQ-011 body_rd_en, body_rd_id / body_rd_data  out, out / in  1, ID_W / BODY_W  read port; data is valid 1 cycle after body_rd_en.
REQ-012 body_wr_en, body_wr_id, body_wr_data  out  1, ID_W, BODY_W  write port.
REQ-013 res_contact, res_obb1, res_obb2  out  CONTACT_W, BODY_W, BODY_W  registered operands to the resolver.
REQ-014 res_imp_x, res_imp_y, res_nudge_x, res_nudge_y, res_rot1, res_rot2  in  32 each  combinational resolver results, pre-aligned to the body field formats.
REQ-015 busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-016 contact_ready SHALL equal (count < FIFO_DEPTH); a push occurs on valid&&ready; a push when full is ignored even if a pop happens in the same cycle.
REQ-017 The FSM SHALL have states IDLE, RD_A, RD_B, LD_B, RESOLVE, WR_A and WR_B.
REQ-018 IDLE with the FIFO non-empty: pop the head; if id_a==id_b or either id >= N_BODIES, drop the entry and stay in IDLE; otherwise latch the entry and go to RD_A.
REQ-019 mem_req SHALL be high in RD_A, RD_B, WR_A and WR_B; in those states the FSM SHALL hold, with rd_en and wr_en low, until mem_gnt=1.
REQ-020 RD_A (granted): body_rd_en=1, rd_id=id_a → RD_B.
REQ-021 RD_B (granted): body_rd_en=1, rd_id=id_b; latch rd_data into obb1 → LD_B.
REQ-022 LD_B: latch rd_data into obb2 → RESOLVE.
REQ-023 RESOLVE: register all six res_* inputs → WR_A.
REQ-024 WR_A (granted): write obb1 to id_a with vel += imp, omega += rot1, pos += nudge.
REQ-025 WR_B (granted): write obb2 to id_b with vel -= imp, omega += rot2, pos -= nudge; next state is RD_A if a valid entry can be popped this cycle, else IDLE.
REQ-026 All field arithmetic SHALL be 32-bit two's-complement wrap, with non-kinematic fields written back unchanged.
REQ-027 Minimum latency, contact pop to WR_B write, SHALL be 6 cycles with continuous grant; throughput is 1 contact per 6 cycles.
REQ-028 Contacts SHALL resolve in FIFO order, and a body's write SHALL complete before any later contact reads it.

Reset
REQ-029 On Reset: FSM→IDLE, FIFO emptied, all outputs and registers 0 (contact_ready=1 after deassertion); an in-flight contact is discarded with no write.

Configuration
REQ-030 Macro CONTACT_RESOLVE_STATS_EN defined: add outputs resolved_count[15:0] (increment on WR_B write) and dropped_count[15:0] (increment on REQ-018 drop), both saturating at 0xFFFF and reset to 0; undefined: these ports and counters do not exist.

Verification
REQ-031 Push ids 1,2 with grant held: reads at cycles 1-2, writes id1 at cycle 5 and id2 at cycle 6; vel1=0x100 and imp=0x40 → vel1=0x140, vel2 old-0x40.
REQ-032 Push 9 contacts back-to-back with no pops: ready falls after the 8th push; the 9th is not accepted.
REQ-033 Push ids 3,3 then 20,1: both dropped, no mem_req, dropped_count=2 with the macro defined.
REQ-034 Hold mem_gnt=0 for 5 cycles in WR_A: no write occurs and the state holds; the write completes on the first granted cycle.
REQ-035 Push (1,2) then (2,4): the second RD of id2 occurs after the first WR of id2 and returns the updated value.
REQ-036 Assert Reset during RESOLVE: no writes, busy=0, FIFO empty, counters 0.

Source files
------------

// File: rtl/contact_resolve_scheduler.sv
// rtl/contact_resolve_scheduler.sv - contact FIFO plus read/resolve/write scheduler over a shared body-state memory port
// Optional stats counters under CONTACT_RESOLVE_STATS_EN. Body fields: pos_x[31:0] pos_y[63:32] vel_x[95:64] vel_y[127:96] omega[159:128].
module contact_resolve_scheduler #(
  parameter int N_BODIES   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CONTACT_W  = 96,
  parameter int BODY_W     = 256,
  parameter int ID_W       = (N_BODIES > 1) ? $clog2(N_BODIES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 contact_valid,
  output logic                 contact_ready,
  input  logic [ID_W-1:0]      contact_id_a,
  input  logic [ID_W-1:0]      contact_id_b,
  input  logic [CONTACT_W-1:0] contact_data,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic                 body_rd_en,
  output logic [ID_W-1:0]      body_rd_id,
  input  logic [BODY_W-1:0]    body_rd_data,
  output logic                 body_wr_en,
  output logic [ID_W-1:0]      body_wr_id,
  output logic [BODY_W-1:0]    body_wr_data,
  output logic [CONTACT_W-1:0] res_contact,
  output logic [BODY_W-1:0]    res_obb1,
  output logic [BODY_W-1:0]    res_obb2,
  input  logic [31:0]          res_imp_x,
  input  logic [31:0]          res_imp_y,
  input  logic [31:0]          res_nudge_x,
  input  logic [31:0]          res_nudge_y,
  input  logic [31:0]          res_rot1,
  input  logic [31:0]          res_rot2,
`ifdef CONTACT_RESOLVE_STATS_EN
  output logic [15:0]          resolved_count,
  output logic [15:0]          dropped_count,
`endif
  output logic                 busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ID_W:0]    N_LIM   = (ID_W + 1)'(N_BODIES);

  localparam int POS_X = 0;
  localparam int POS_Y = 32;
  localparam int VEL_X = 64;
  localparam int VEL_Y = 96;
  localparam int OMEGA = 128;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_A    = 3'd1;
  localparam logic [2:0] S_RD_B    = 3'd2;
  localparam logic [2:0] S_LD_B    = 3'd3;
  localparam logic [2:0] S_RESOLVE = 3'd4;
  localparam logic [2:0] S_WR_A    = 3'd5;
  localparam logic [2:0] S_WR_B    = 3'd6;

  logic [ID_W-1:0]      fifo_a [FIFO_DEPTH];
  logic [ID_W-1:0]      fifo_b [FIFO_DEPTH];
  logic [CONTACT_W-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  logic [2:0]           state, state_nxt;
  logic [ID_W-1:0]      id_a, id_b;
  logic [CONTACT_W-1:0] contact_q;
  logic [BODY_W-1:0]    obb1, obb2;
  logic                 rd_a_done;
  logic [31:0]          imp_x_q, imp_y_q, nudge_x_q, nudge_y_q, rot1_q, rot2_q;
  logic [BODY_W-1:0]    upd_a, upd_b;

  logic [ID_W-1:0]      head_a, head_b;
  logic [CONTACT_W-1:0] head_d;
  logic                 head_ok, fifo_ne, push, pop, take, drop, wr_b_go;

  assign head_a  = fifo_a[rd_ptr];
  assign head_b  = fifo_b[rd_ptr];
  assign head_d  = fifo_d[rd_ptr];
  assign fifo_ne = (count != '0);
  assign head_ok = (head_a != head_b) && ({1'b0, head_a} < N_LIM) && ({1'b0, head_b} < N_LIM);

  assign contact_ready = !rst && (count < DEPTH_C);
  assign push    = contact_valid && contact_ready;
  assign wr_b_go = (state == S_WR_B) && mem_gnt;
  // WR_B only chains into the next contact when the head is resolvable; bad heads are dropped from IDLE
  assign pop     = fifo_ne && ((state == S_IDLE) || (wr_b_go && head_ok));
  assign take    = pop && head_ok;
  assign drop    = pop && !head_ok;

  assign busy        = (state != S_IDLE) || fifo_ne;
  assign mem_req     = (state == S_RD_A) || (state == S_RD_B) || (state == S_WR_A) || (state == S_WR_B);
  assign body_rd_en  = ((state == S_RD_A) || (state == S_RD_B)) && mem_gnt;
  assign body_wr_en  = ((state == S_WR_A) || (state == S_WR_B)) && mem_gnt;
  assign body_rd_id  = !body_rd_en ? '0 : (state == S_RD_A) ? id_a : id_b;
  assign body_wr_id  = !body_wr_en ? '0 : (state == S_WR_A) ? id_a : id_b;
  assign body_wr_data = !body_wr_en ? '0 : (state == S_WR_A) ? upd_a : upd_b;

  assign res_contact = contact_q;
  assign res_obb1    = obb1;
  assign res_obb2    = obb2;

  always_comb begin
    upd_a = obb1;
    upd_a[POS_X +: 32] = obb1[POS_X +: 32] + nudge_x_q;
    upd_a[POS_Y +: 32] = obb1[POS_Y +: 32] + nudge_y_q;
    upd_a[VEL_X +: 32] = obb1[VEL_X +: 32] + imp_x_q;
    upd_a[VEL_Y +: 32] = obb1[VEL_Y +: 32] + imp_y_q;
    upd_a[OMEGA +: 32] = obb1[OMEGA +: 32] + rot1_q;
    upd_b = obb2;
    upd_b[POS_X +: 32] = obb2[POS_X +: 32] - nudge_x_q;
    upd_b[POS_Y +: 32] = obb2[POS_Y +: 32] - nudge_y_q;
    upd_b[VEL_X +: 32] = obb2[VEL_X +: 32] - imp_x_q;
    upd_b[VEL_Y +: 32] = obb2[VEL_Y +: 32] - imp_y_q;
    upd_b[OMEGA +: 32] = obb2[OMEGA +: 32] + rot2_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (take) state_nxt = S_RD_A;
      S_RD_A:    if (mem_gnt) state_nxt = S_RD_B;
      S_RD_B:    if (mem_gnt) state_nxt = S_LD_B;
      S_LD_B:    state_nxt = S_RESOLVE;
      S_RESOLVE: state_nxt = S_WR_A;
      S_WR_A:    if (mem_gnt) state_nxt = S_WR_B;
      S_WR_B:    if (mem_gnt) state_nxt = take ? S_RD_A : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      id_a      <= '0;
      id_b      <= '0;
      contact_q <= '0;
      obb1      <= '0;
      obb2      <= '0;
      rd_a_done <= 1'b0;
      imp_x_q   <= '0;
      imp_y_q   <= '0;
      nudge_x_q <= '0;
      nudge_y_q <= '0;
      rot1_q    <= '0;
      rot2_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_a[i] <= '0;
        fifo_b[i] <= '0;
        fifo_d[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (push) begin
        fifo_a[wr_ptr] <= contact_id_a;
        fifo_b[wr_ptr] <= contact_id_b;
        fifo_d[wr_ptr] <= contact_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (take) begin
        id_a      <= head_a;
        id_b      <= head_b;
        contact_q <= head_d;
      end
      // body A's data returns in the cycle after its granted read, even if RD_B is still waiting for grant
      rd_a_done <= (state == S_RD_A) && mem_gnt;
      if (rd_a_done) obb1 <= body_rd_data;
      if (state == S_LD_B) obb2 <= body_rd_data;
      if (state == S_RESOLVE) begin
        imp_x_q   <= res_imp_x;
        imp_y_q   <= res_imp_y;
        nudge_x_q <= res_nudge_x;
        nudge_y_q <= res_nudge_y;
        rot1_q    <= res_rot1;
        rot2_q    <= res_rot2;
      end
    end
  end

`ifdef CONTACT_RESOLVE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolved_count <= '0;
      dropped_count  <= '0;
    end else begin
      if (wr_b_go && (resolved_count != 16'hFFFF)) resolved_count <= resolved_count + 1'b1;
      if (drop && (dropped_count != 16'hFFFF))     dropped_count  <= dropped_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_contact_resolve_scheduler.sv
// tb/tb_contact_resolve_scheduler.sv - scoreboard bench for contact_resolve_scheduler
// Stats checks compile in when CONTACT_RESOLVE_STATS_EN is defined.
module tb_contact_resolve_scheduler;
  localparam int N_BODIES   = 20;
  localparam int FIFO_DEPTH = 8;
  localparam int CONTACT_W  = 96;
  localparam int BODY_W     = 256;
  localparam int ID_W       = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 contact_valid = 1'b0;
  logic                 contact_ready;
  logic [ID_W-1:0]      contact_id_a = '0;
  logic [ID_W-1:0]      contact_id_b = '0;
  logic [CONTACT_W-1:0] contact_data = '0;
  logic                 mem_req;
  logic                 mem_gnt = 1'b1;
  logic                 body_rd_en;
  logic [ID_W-1:0]      body_rd_id;
  logic [BODY_W-1:0]    body_rd_data;
  logic                 body_wr_en;
  logic [ID_W-1:0]      body_wr_id;
  logic [BODY_W-1:0]    body_wr_data;
  logic [CONTACT_W-1:0] res_contact;
  logic [BODY_W-1:0]    res_obb1, res_obb2;
  logic [31:0]          res_imp_x, res_imp_y, res_nudge_x, res_nudge_y, res_rot1, res_rot2;
  logic                 busy;
`ifdef CONTACT_RESOLVE_STATS_EN
  logic [15:0]          resolved_count, dropped_count;
`endif

  always #5 clk = ~clk;

  contact_resolve_scheduler #(
    .N_BODIES(N_BODIES), .FIFO_DEPTH(FIFO_DEPTH), .CONTACT_W(CONTACT_W), .BODY_W(BODY_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .contact_valid(contact_valid), .contact_ready(contact_ready),
    .contact_id_a(contact_id_a), .contact_id_b(contact_id_b), .contact_data(contact_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt),
    .body_rd_en(body_rd_en), .body_rd_id(body_rd_id), .body_rd_data(body_rd_data),
    .body_wr_en(body_wr_en), .body_wr_id(body_wr_id), .body_wr_data(body_wr_data),
    .res_contact(res_contact), .res_obb1(res_obb1), .res_obb2(res_obb2),
    .res_imp_x(res_imp_x), .res_imp_y(res_imp_y), .res_nudge_x(res_nudge_x),
    .res_nudge_y(res_nudge_y), .res_rot1(res_rot1), .res_rot2(res_rot2),
`ifdef CONTACT_RESOLVE_STATS_EN
    .resolved_count(resolved_count), .dropped_count(dropped_count),
`endif
    .busy(busy)
  );

  // Resolver stand-in: some results come from the contact, some from the latched bodies
  assign res_imp_x   = res_contact[31:0];
  assign res_imp_y   = res_contact[63:32];
  assign res_nudge_x = res_contact[95:64];
  assign res_nudge_y = res_obb1[31:0] ^ res_obb2[31:0];
  assign res_rot1    = res_obb2[159:128];
  assign res_rot2    = res_obb1[159:128] + 32'd7;

  function automatic logic [BODY_W-1:0] init_body(input int i);
    logic [BODY_W-1:0] b;
    b = '0;
    b[31:0]    = 32'(i) * 32'h1000 + 32'h11;
    b[63:32]   = 32'(i) * 32'd3;
    b[95:64]   = 32'(i) * 32'h100;
    b[127:96]  = -32'(i);
    b[159:128] = 32'(i) << 8;
    b[255:160] = {3{32'hC0DE_0000 | 32'(i)}};
    return b;
  endfunction

  logic [BODY_W-1:0] mem [N_BODIES];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BODIES; i++) mem[i] <= init_body(i);
      body_rd_data <= '0;
    end else begin
      if (body_wr_en) mem[body_wr_id] <= body_wr_data;
      if (body_rd_en) body_rd_data <= mem[body_rd_id];
    end
  end

  typedef struct { int id; logic [BODY_W-1:0] data; } exp_t;
  typedef struct { int cyc; int id; logic [BODY_W-1:0] data; } ev_t;

  logic [BODY_W-1:0] ref_mem [N_BODIES];
  exp_t sb[$];
  ev_t  rd_log[$];
  ev_t  wr_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   req_cycles = 0;
  logic seen_ready, seen_req, seen_busy, seen_rd_en, seen_wr_en;

  task automatic check(input string tag, input logic [BODY_W-1:0] obs, input logic [BODY_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < N_BODIES; i++) ref_mem[i] = init_body(i);
    sb.delete();
  endtask

  task automatic sb_contact(input int a, input int b, input logic [95:0] d);
    logic [BODY_W-1:0] o1, o2, n1, n2;
    logic [31:0] ny, r1, r2;
    o1 = ref_mem[a];
    o2 = ref_mem[b];
    ny = o1[31:0] ^ o2[31:0];
    r1 = o2[159:128];
    r2 = o1[159:128] + 32'd7;
    n1 = o1;
    n1[31:0]    = o1[31:0]    + d[95:64];
    n1[63:32]   = o1[63:32]   + ny;
    n1[95:64]   = o1[95:64]   + d[31:0];
    n1[127:96]  = o1[127:96]  + d[63:32];
    n1[159:128] = o1[159:128] + r1;
    n2 = o2;
    n2[31:0]    = o2[31:0]    - d[95:64];
    n2[63:32]   = o2[63:32]   - ny;
    n2[95:64]   = o2[95:64]   - d[31:0];
    n2[127:96]  = o2[127:96]  - d[63:32];
    n2[159:128] = o2[159:128] + r2;
    ref_mem[a] = n1;
    ref_mem[b] = n2;
    sb.push_back('{id: a, data: n1});
    sb.push_back('{id: b, data: n2});
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    seen_ready = contact_ready;
    seen_req   = mem_req;
    seen_busy  = busy;
    seen_rd_en = body_rd_en;
    seen_wr_en = body_wr_en;
    if (mem_req) req_cycles++;
    if (body_rd_en) rd_log.push_back('{cyc: cyc, id: int'(body_rd_id), data: '0});
    if (body_wr_en) begin
      wr_log.push_back('{cyc: cyc, id: int'(body_wr_id), data: body_wr_data});
      if (sb.size() == 0) begin
        check("unexpected_write", BODY_W'(body_wr_en), '0);
      end else begin
        e = sb.pop_front();
        check("wr_id", BODY_W'(body_wr_id), BODY_W'(e.id));
        check("wr_data", body_wr_data, e.data);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int a, input int b, input logic [95:0] d, input bit acc);
    contact_valid = 1'b1;
    contact_id_a  = ID_W'(a);
    contact_id_b  = ID_W'(b);
    contact_data  = d;
    tick();
    contact_valid = 1'b0;
    check("push_ready", BODY_W'(seen_ready), BODY_W'(acc));
    if (acc && a != b && a < N_BODIES && b < N_BODIES) sb_contact(a, b, d);
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < max) begin
      tick();
      n++;
    end
    check("drain_sb_empty", BODY_W'(sb.size()), '0);
    check("drain_idle", BODY_W'(busy), '0);
  endtask

  function automatic logic [95:0] mk(input logic [31:0] ix, input logic [31:0] iy, input logic [31:0] nx);
    return {nx, iy, ix};
  endfunction

  int c;

  initial begin
    ref_reset();
    repeat (3) tick();
    check("rst_ready", BODY_W'(contact_ready), '0);
    check("rst_busy", BODY_W'(busy), '0);
    check("rst_mem_req", BODY_W'(mem_req), '0);
    check("rst_wr_en", BODY_W'(body_wr_en), '0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", BODY_W'(seen_ready), 1);
    check("post_rst_busy", BODY_W'(seen_busy), '0);
`ifdef CONTACT_RESOLVE_STATS_EN
    check("rst_resolved_count", BODY_W'(resolved_count), '0);
    check("rst_dropped_count", BODY_W'(dropped_count), '0);
`endif

    // Invalid contacts are dropped without touching memory
    req_cycles = 0;
    push(3, 3, mk(32'h1, 32'h2, 32'h3), 1'b1);
    push(20, 1, mk(32'h1, 32'h2, 32'h3), 1'b1);
    repeat (8) tick();
    check("drop_no_mem_req", BODY_W'(req_cycles), '0);
    check("drop_idle", BODY_W'(busy), '0);
`ifdef CONTACT_RESOLVE_STATS_EN
    check("dropped_count", BODY_W'(dropped_count), 2);
`endif

    // Single contact timing and velocity update
    rd_log.delete();
    wr_log.delete();
    c = cyc;
    push(1, 2, mk(32'h40, 32'h8, 32'h3), 1'b1);
    wait_drain(40);
    check("t1_rd_count", BODY_W'(rd_log.size()), 2);
    check("t1_wr_count", BODY_W'(wr_log.size()), 2);
    check("t1_rd0_cyc", BODY_W'(rd_log[0].cyc), BODY_W'(c + 2));
    check("t1_rd0_id", BODY_W'(rd_log[0].id), 1);
    check("t1_rd1_cyc", BODY_W'(rd_log[1].cyc), BODY_W'(c + 3));
    check("t1_rd1_id", BODY_W'(rd_log[1].id), 2);
    check("t1_wr0_cyc", BODY_W'(wr_log[0].cyc), BODY_W'(c + 6));
    check("t1_wr1_cyc", BODY_W'(wr_log[1].cyc), BODY_W'(c + 7));
    check("t1_vel1", BODY_W'(wr_log[0].data[95:64]), 32'h140);
    check("t1_vel2", BODY_W'(wr_log[1].data[95:64]), 32'h1C0);

    // Back-to-back contacts sharing body 2: second read follows first write
    rd_log.delete();
    wr_log.delete();
    c = cyc;
    push(1, 2, mk(32'h11, 32'h22, 32'h33), 1'b1);
    push(2, 4, mk(32'hFFFF_FFF0, 32'h5, 32'h80000001), 1'b1);
    wait_drain(60);
    check("t2_rd_count", BODY_W'(rd_log.size()), 4);
    check("t2_wr_count", BODY_W'(wr_log.size()), 4);
    check("t2_wr_b_cyc", BODY_W'(wr_log[1].cyc), BODY_W'(c + 7));
    check("t2_rd2_cyc", BODY_W'(rd_log[2].cyc), BODY_W'(c + 8));
    check("t2_rd2_id", BODY_W'(rd_log[2].id), 2);
    check("t2_rd_after_wr", BODY_W'(rd_log[2].cyc > wr_log[1].cyc), 1);
    check("t2_wr3_cyc", BODY_W'(wr_log[3].cyc), BODY_W'(c + 13));

    // Grant withheld for 5 cycles in WR_A
    rd_log.delete();
    wr_log.delete();
    c = cyc;
    push(5, 6, mk(32'h7, 32'h9, 32'hB), 1'b1);
    while (cyc < c + 6) tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wr_hold_req", BODY_W'(seen_req), 1);
      check("wr_hold_wr_en", BODY_W'(seen_wr_en), '0);
    end
    mem_gnt = 1'b1;
    wait_drain(40);
    check("t3_wr_count", BODY_W'(wr_log.size()), 2);
    check("t3_wr0_cyc", BODY_W'(wr_log[0].cyc), BODY_W'(c + 11));
    check("t3_wr1_cyc", BODY_W'(wr_log[1].cyc), BODY_W'(c + 12));

    // FIFO fill while the FSM is stalled in RD_A
    mem_gnt = 1'b0;
    push(10, 11, mk($urandom, $urandom, $urandom), 1'b1);
    repeat (2) tick();
    for (int i = 0; i < 9; i++) push(i, i + 10, mk($urandom, $urandom, $urandom), i < 8);
    tick();
    check("full_ready", BODY_W'(seen_ready), '0);
    check("stall_req", BODY_W'(seen_req), 1);
    check("stall_rd_en", BODY_W'(seen_rd_en), '0);
    mem_gnt = 1'b1;
    wait_drain(200);
`ifdef CONTACT_RESOLVE_STATS_EN
    check("resolved_count", BODY_W'(resolved_count), 13);
`endif

    // Reset during RESOLVE discards the in-flight contact
    rd_log.delete();
    wr_log.delete();
    c = cyc;
    push(7, 8, mk(32'h3, 32'h4, 32'h5), 1'b1);
    while (cyc < c + 5) tick();
    #2;
    rst = 1'b1;
    #1;
    check("pre_reset_no_write", BODY_W'(wr_log.size()), '0);
    check("inflight_rst_busy", BODY_W'(busy), '0);
    check("inflight_rst_mem_req", BODY_W'(mem_req), '0);
    check("inflight_rst_wr_en", BODY_W'(body_wr_en), '0);
`ifdef CONTACT_RESOLVE_STATS_EN
    check("inflight_rst_resolved", BODY_W'(resolved_count), '0);
    check("inflight_rst_dropped", BODY_W'(dropped_count), '0);
`endif
    ref_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("post_rst_no_write", BODY_W'(wr_log.size()), '0);
    check("post_rst2_busy", BODY_W'(seen_busy), '0);
    check("post_rst2_ready", BODY_W'(seen_ready), 1);
    push(7, 8, mk(32'h3, 32'h4, 32'h5), 1'b1);
    wait_drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
